// File: rtl/safety_err_collector.sv
// Dual-rail parity error collector: rail check, edge events, sticky status, saturating counters,
// level IRQ with valid/ready clear. Optional fault injection input under SAFETY_ERR_COLLECTOR_FI_EN.
module safety_err_collector #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MISMATCH_CYC = 2
) (
  input  logic                     ACLK,
  input  logic                     RESETN_ACLK,
  input  logic [NUM_SRC-1:0]       ERR_IN,
  input  logic [NUM_SRC-1:0]       ERR_IN_B,
  input  logic [NUM_SRC-1:0]       ENERR,
`ifdef SAFETY_ERR_COLLECTOR_FI_EN
  input  logic [NUM_SRC-1:0]       FIERR,
`endif
  input  logic                     CLR_VALID,
  input  logic [NUM_SRC-1:0]       CLR_MASK,
  output logic                     CLR_READY,
  output logic [NUM_SRC-1:0]       ERR_STICKY,
  output logic [NUM_SRC*CNT_W-1:0] ERR_CNT,
  output logic                     IRQ,
  output logic [NUM_SRC-1:0]       RAIL_FAULT
);

  typedef enum logic [1:0] {StIdle, StActive, StClearing} state_e;

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [3:0]       MmMax    = 4'hf;
  localparam logic [3:0]       MmThresh = 4'(MISMATCH_CYC);

  state_e state_q, state_d;

  logic [NUM_SRC-1:0] err_q, err_qq, errb_q;
  logic [NUM_SRC-1:0] sticky_q, sticky_d;
  logic [NUM_SRC-1:0] rail_fault_q, rail_fault_d;
  logic [NUM_SRC-1:0] rail_set;
  logic [NUM_SRC-1:0] ev, fi_ev, clr_bits;
  logic               clr_hs;

  logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0][3:0]       mm_cnt_q, mm_cnt_d;

  // Complement rail resets to ones so the reset pattern reads as a matched pair.
  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      err_q  <= '0;
      err_qq <= '0;
      errb_q <= '1;
    end else begin
      err_q  <= ERR_IN;
      err_qq <= err_q;
      errb_q <= ERR_IN_B;
    end
  end

`ifdef SAFETY_ERR_COLLECTOR_FI_EN
  logic [NUM_SRC-1:0] fierr_q, fierr_qq;

  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      fierr_q  <= '0;
      fierr_qq <= '0;
    end else begin
      fierr_q  <= FIERR;
      fierr_qq <= fierr_q;
    end
  end

  assign fi_ev = fierr_q & ~fierr_qq;
`else
  assign fi_ev = '0;
`endif

  assign ev        = (err_q & ~err_qq & ENERR) | fi_ev;
  assign CLR_READY = (state_q != StClearing);
  assign IRQ       = (state_q == StActive);
  assign clr_hs    = CLR_VALID & CLR_READY;
  assign clr_bits  = {NUM_SRC{clr_hs}} & CLR_MASK;

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    mm_cnt_d = mm_cnt_q;
    rail_set = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // An event in the clear cycle wins over the clear: counter restarts at one.
      if (ev[i]) begin
        sticky_d[i] = 1'b1;
        if (clr_bits[i]) begin
          cnt_d[i] = CNT_W'(1);
        end else if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (clr_bits[i]) begin
        sticky_d[i] = 1'b0;
        cnt_d[i]    = '0;
      end

      if (err_q[i] == errb_q[i]) begin
        mm_cnt_d[i] = (mm_cnt_q[i] == MmMax) ? mm_cnt_q[i] : mm_cnt_q[i] + 4'd1;
      end else begin
        mm_cnt_d[i] = 4'd0;
      end
      rail_set[i] = (mm_cnt_d[i] >= MmThresh) & ~rail_fault_q[i];
    end
    rail_fault_d = rail_fault_q | rail_set;
  end

  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      sticky_q     <= '0;
      cnt_q        <= '0;
      mm_cnt_q     <= '0;
      rail_fault_q <= '0;
      state_q      <= StIdle;
    end else begin
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
      mm_cnt_q     <= mm_cnt_d;
      rail_fault_q <= rail_fault_d;
      state_q      <= state_d;
    end
  end

  // Exit from clearing looks at next-state status so events landing in that cycle re-raise IRQ.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clr_hs) begin
          state_d = StClearing;
        end else if ((|ev) || (|rail_set)) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (clr_hs) begin
          state_d = StClearing;
        end
      end
      StClearing: begin
        state_d = ((|sticky_d) || (|rail_fault_d)) ? StActive : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ERR_STICKY = sticky_q;
  assign ERR_CNT    = cnt_q;
  assign RAIL_FAULT = rail_fault_q;

endmodule
